cmp_share_ctrl: RTL and testbench

- Shares one 32-bit magnitude comparator (signed or unsigned per request) between NREQ requesters.
- Uses round-robin arbitration, a valid/ready request handshake per requester, and one registered response channel tagged with the requester id.
- Sits between the branch/set-less-than issue logic and the single comparator instance. This avoids replicating the 32-bit compare chain per consumer.

---
 rtl/cmp_share_ctrl_pkg.sv | 34 +++
 rtl/cmp_share_ctrl_rr_arbiter.sv | 35 +++
 rtl/cmp_share_ctrl.sv | 129 ++++++++++++
 tb/tb_cmp_share_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_ctrl_pkg.sv
// Shared definitions for the shared 32-bit comparator controller:
// FSM state encoding, operand width and the signed-capable compare function.
package cmp_share_ctrl_pkg;

   localparam int unsigned CMP_W = 32;

   typedef enum logic [1:0] {
      CMP_IDLE = 2'd0,
      CMP_CMP  = 2'd1,
      CMP_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_res_t;

   // Differing sign bits decide a signed compare outright; otherwise magnitude wins.
   function automatic cmp_res_t cmp32(input logic [CMP_W-1:0] a,
                                      input logic [CMP_W-1:0] b,
                                      input logic             sgn);
      cmp_res_t r;
      r.eq = (a == b);
      r.gt = (a > b);
      r.lt = (a < b);
      if (sgn && (a[CMP_W-1] != b[CMP_W-1])) begin
         r.gt = b[CMP_W-1];
         r.lt = a[CMP_W-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/cmp_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// after ptr (wrapping), plus the encoded grant index.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gid
);

   always_comb begin
      logic found;
      grant = '0;
      gid   = '0;
      found = 1'b0;
      // Two passes: indices above ptr first, then wrap to 0..ptr.
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && (i > 32'(ptr)) && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gid      = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && (i <= 32'(ptr)) && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gid      = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Shares one signed/unsigned 32-bit comparator between NREQ requesters using
// round-robin arbitration and a single registered, id-tagged response channel.
module cmp_share_ctrl
   import cmp_share_ctrl_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2,
   parameter int unsigned W    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0] req_signed,
   output logic [NREQ-1:0] req_ready,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic            rsp_gt,
   output logic            rsp_lt,
   output logic            rsp_eq
);

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           sgn_q, sgn_d;
   logic [IDW-1:0] id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   cmp_res_t       res_q, res_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gid;
   cmp_res_t        cmp_out;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .gid   (gid)
   );

   assign cmp_out = cmp32(a_q, b_q, sgn_q);

   always_comb begin
      req_ready = '0;
      if ((state_q == CMP_IDLE) && !reset) begin
         req_ready = grant;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      sgn_d       = sgn_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      res_d       = res_q;
      case (state_q)
         CMP_IDLE: begin
            if (|grant) begin
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (grant[i]) begin
                     a_d   = req_a[i*W +: W];
                     b_d   = req_b[i*W +: W];
                     sgn_d = req_signed[i];
                  end
               end
               id_d    = gid;
               ptr_d   = gid;
               state_d = CMP_CMP;
            end
         end
         CMP_CMP: begin
            res_d       = cmp_out;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = CMP_RESP;
         end
         CMP_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = CMP_IDLE;
            end
         end
         default: state_d = CMP_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= CMP_IDLE;
         ptr_q       <= IDW'(NREQ - 1);
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sgn_q       <= sgn_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         res_q       <= res_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_gt    = res_q.gt;
   assign rsp_lt    = res_q.lt;
   assign rsp_eq    = res_q.eq;

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl: compare semantics, latency, round-robin
// order, backpressure, withdrawn requests and reset mid-flight.
module tb_cmp_share_ctrl;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
   localparam int unsigned W    = 32;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_signed;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_gt;
   logic              rsp_lt;
   logic              rsp_eq;

   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   cmp_share_ctrl #(
      .NREQ (NREQ),
      .IDW  (IDW),
      .W    (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_gt     (rsp_gt),
      .rsp_lt     (rsp_lt),
      .rsp_eq     (rsp_eq)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_signed[id]   = s;
   endtask

   // Single request from IDLE with rsp_ready high; ends back in IDLE.
   task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] exp);
      set_ops(id, a, b, s);
      req_valid = NREQ'(1 << id);
      #1 check("grant", req_ready, 64'(1 << id));
      tick();
      req_valid = '0;
      check("cmp_busy", {req_ready, rsp_valid}, 0);
      tick();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, id);
      check("rsp_flags", {rsp_gt, rsp_lt, rsp_eq}, exp);
      tick();
      check("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};

      reset      = 1'b1;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      req_signed = '0;
      rsp_ready  = 1'b1;
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_id", rsp_id, 0);
      check("rst_flags", {rsp_gt, rsp_lt, rsp_eq}, 0);
      req_valid = '0;
      #10 reset = 1'b0;
      tick();

      // Compare semantics and T+2 latency
      do_req(0, 32'd5, 32'd3, 1'b0, GT);
      do_req(2, 32'hFFFF_FFFF, 32'd1, 1'b1, LT);
      do_req(2, 32'hFFFF_FFFF, 32'd1, 1'b0, GT);
      do_req(2, 32'h8000_0000, 32'h8000_0000, 1'b1, EQ);
      do_req(2, 32'h8000_0000, 32'h8000_0000, 1'b0, EQ);
      do_req(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT);
      do_req(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT);
      do_req(3, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, GT);

      // Round robin, all requesting; pointer last set to 3 so order starts at 0
      for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd2, 1'b0);
      req_valid = '1;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("rr_grant", req_ready, 64'(1 << order[k]));
         tick();
         check("rr_busy", req_ready, 0);
         tick();
         check("rr_valid", rsp_valid, 1);
         check("rr_id", rsp_id, order[k]);
         check("rr_flags", {rsp_gt, rsp_lt, rsp_eq},
               (order[k] < 2) ? LT : ((order[k] == 2) ? EQ : GT));
         tick();
      end
      req_valid = '0;

      // Backpressure: pointer at 0, requesters 1 and 2 pending
      set_ops(1, 32'd10, 32'd20, 1'b0);
      set_ops(2, 32'd7, 32'd7, 1'b0);
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      #1 check("bp_grant", req_ready, 4'b0010);
      tick();
      req_valid = 4'b0100;
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_flags", {rsp_gt, rsp_lt, rsp_eq}, LT);
      repeat (5) begin
         tick();
         check("bp_hold", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, req_ready},
               {1'b1, 2'd1, LT, 4'b0000});
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release", rsp_valid, 0);
      check("bp_next_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      check("bp_next_busy", req_ready, 0);
      tick();
      check("bp_next_id", rsp_id, 2);
      check("bp_next_flags", {rsp_valid, rsp_gt, rsp_lt, rsp_eq}, {1'b1, EQ});
      tick();

      // Withdrawn request: requester 1 pulses valid only while in RESP
      rsp_ready = 1'b0;
      set_ops(3, 32'd1, 32'd2, 1'b0);
      req_valid = 4'b1000;
      #1 check("wd_grant", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      tick();
      check("wd_rsp", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd3, LT});
      req_valid = 4'b0010;
      #1 check("wd_no_grant", req_ready, 0);
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      check("wd_idle", {rsp_valid, req_ready}, 0);
      set_ops(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      req_valid = 4'b0101;
      #1 check("wd_ptr_kept", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check("wd_after", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd0, LT});
      tick();

      // Reset while in CMP: request abandoned, pointer back to NREQ-1
      req_valid = 4'b0100;
      #1 check("rm_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      reset     = 1'b1;
      #1 check("rm_in_reset", {rsp_valid, req_ready}, 0);
      tick();
      reset = 1'b0;
      tick();
      check("rm_no_rsp1", rsp_valid, 0);
      tick();
      check("rm_no_rsp2", rsp_valid, 0);
      req_valid = '1;
      #1 check("rm_restart_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check("rm_restart_rsp", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd0, LT});
      tick();
      check("rm_restart_drop", rsp_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
